// File: rtl/stream_arbiter_mux.sv
// Round-robin packet arbiter muxing CHANNELS valid/ready streams into one
// registered output stream; a granted channel holds the output until its last beat.
module stream_arbiter_mux #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  input  logic [CHANNELS-1:0]       i_last,
  output logic [CHANNELS-1:0]       o_ready,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_valid,
  output logic                      o_last,
  output logic [SELW-1:0]           o_channel,
  input  logic                      i_ready
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   lock_q, lock_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic [SELW-1:0]   chan_q, chan_d;

  logic              load_en;
  logic              rr_found;
  logic [SELW-1:0]   rr_idx;
  logic [SELW-1:0]   cand_idx;
  int unsigned       cand;
  logic [SELW-1:0]   grant_idx;
  logic              grant_vld;
  logic [CHANNELS-1:0] grant_oh;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_last;
  logic              xfer;

  assign load_en = !valid_q || i_ready;

  // Round-robin search starting one past the last packet-completing channel
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      cand_idx = SELW'(cand);
      if (!rr_found && i_valid[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // While locked only the owning channel may be granted, even when it idles
  always_comb begin
    grant_idx = rr_idx;
    grant_vld = rr_found;
    if (state_q == ST_LOCKED) begin
      grant_idx = lock_q;
      grant_vld = i_valid[lock_q];
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      grant_oh[k] = grant_vld && (grant_idx == SELW'(k));
      if (grant_oh[k]) begin
        sel_data = i_data[k*WIDTH +: WIDTH];
        sel_last = i_last[k];
      end
    end
  end

  assign xfer    = grant_vld && load_en && i_rst_n;
  assign o_ready = (load_en && i_rst_n) ? grant_oh : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
      ptr_q   <= SELW'(CHANNELS - 1);
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    chan_d  = chan_q;

    if (xfer) begin
      data_d  = sel_data;
      last_d  = sel_last;
      chan_d  = grant_idx;
      valid_d = 1'b1;
      if (sel_last) ptr_d = grant_idx;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer && !sel_last) begin
          state_d = ST_LOCKED;
          lock_d  = grant_idx;
        end
      end
      ST_LOCKED: begin
        if (xfer && sel_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_data    = data_q;
  assign o_last    = last_q;
  assign o_valid   = valid_q;
  assign o_channel = chan_q;

endmodule

// File: tb/tb_stream_arbiter_mux.sv
// Directed bench for stream_arbiter_mux: expected output beats are queued at
// issue time and popped by independent monitors on each output transfer.
module tb_stream_arbiter_mux;

  typedef struct packed {
    logic [3:0]  ch;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic         clk;
  logic         rst_n;

  logic [127:0] data4;
  logic [3:0]   v4, l4, r4;
  logic [31:0]  od4;
  logic         ov4, ol4, ir4;
  logic [1:0]   oc4;

  logic [95:0]  data3;
  logic [2:0]   v3, l3, r3;
  logic [31:0]  od3;
  logic         ov3, ol3, ir3;
  logic [1:0]   oc3;

  beat_t q4[$];
  beat_t q3[$];
  beat_t e4, e3;

  int n_checks = 0;
  int n_fail   = 0;

  stream_arbiter_mux #(.WIDTH(32), .CHANNELS(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data4), .i_valid(v4), .i_last(l4),
    .o_ready(r4), .o_data(od4), .o_valid(ov4), .o_last(ol4), .o_channel(oc4),
    .i_ready(ir4)
  );

  stream_arbiter_mux #(.WIDTH(32), .CHANNELS(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data3), .i_valid(v3), .i_last(l3),
    .o_ready(r3), .o_data(od3), .o_valid(ov3), .o_last(ol3), .o_channel(oc3),
    .i_ready(ir3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: one comparison set per output transfer
  always @(negedge clk) begin
    if (rst_n && ov4 && ir4) begin
      if (q4.size() == 0) begin
        chk("unexpected_beat4", 64'(od4), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e4 = q4.pop_front();
        chk("chan4", 64'(oc4), 64'(e4.ch[1:0]));
        chk("data4", 64'(od4), 64'(e4.data));
        chk("last4", 64'(ol4), 64'(e4.last));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov3 && ir3) begin
      if (q3.size() == 0) begin
        chk("unexpected_beat3", 64'(od3), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e3 = q3.pop_front();
        chk("chan3", 64'(oc3), 64'(e3.ch[1:0]));
        chk("data3", 64'(od3), 64'(e3.data));
        chk("last3", 64'(ol3), 64'(e3.last));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic push4(input int ch, input logic [31:0] d, input logic last);
    beat_t b;
    b.ch = 4'(ch); b.data = d; b.last = last;
    q4.push_back(b);
  endtask

  task automatic push3(input int ch, input logic [31:0] d, input logic last);
    beat_t b;
    b.ch = 4'(ch); b.data = d; b.last = last;
    q3.push_back(b);
  endtask

  task automatic tick4(input logic [3:0] exp_r, input string nm);
    @(negedge clk);
    chk(nm, 64'(r4), 64'(exp_r));
    @(posedge clk); #1;
  endtask

  task automatic tick3(input logic [2:0] exp_r, input string nm);
    @(negedge clk);
    chk(nm, 64'(r3), 64'(exp_r));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q4.size() == 0 && q3.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_q4", 64'(q4.size()), 64'd0);
    chk("drain_q3", 64'(q3.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v4 = '0; l4 = '0; data4 = '0; ir4 = 1'b1;
    v3 = '0; l3 = '0; data3 = '0; ir3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    v4 = 4'b1111; l4 = 4'b1111; data4 = {4{32'hFFFF_FFFF}}; ir4 = 1'b1;
    v3 = 3'b111;  l3 = 3'b111;  data3 = '0; ir3 = 1'b1;
    #3;
    chk("rst_valid", 64'(ov4), 64'd0);
    chk("rst_data",  64'(od4), 64'd0);
    chk("rst_chan",  64'(oc4), 64'd0);
    chk("rst_last",  64'(ol4), 64'd0);
    chk("rst_ready", 64'(r4),  64'd0);
    chk("rst_ready3", 64'(r3), 64'd0);
    do_reset();

    // Round robin with single-beat packets on every channel
    v4 = 4'b1111; l4 = 4'b1111;
    data4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    push4(0, 32'hA0, 1'b1); tick4(4'b0001, "rr_ready0");
    push4(1, 32'hA1, 1'b1); tick4(4'b0010, "rr_ready1");
    push4(2, 32'hA2, 1'b1); tick4(4'b0100, "rr_ready2");
    push4(3, 32'hA3, 1'b1); tick4(4'b1000, "rr_ready3");
    push4(0, 32'hA0, 1'b1); tick4(4'b0001, "rr_ready0b");
    push4(1, 32'hA1, 1'b1); tick4(4'b0010, "rr_ready1b");
    v4 = '0;
    drain();
    do_reset();

    // Packet lock: ch1 three beats, ch2 waiting, ch1 bubbles once
    v4 = 4'b0110; l4 = 4'b0100;
    data4[32 +: 32] = 32'hB1; data4[64 +: 32] = 32'hC2;
    push4(1, 32'hB1, 1'b0); tick4(4'b0010, "lock_b1");
    v4 = 4'b0100;
    tick4(4'b0000, "lock_bubble");
    v4 = 4'b0110; data4[32 +: 32] = 32'hB2;
    push4(1, 32'hB2, 1'b0); tick4(4'b0010, "lock_b2");
    l4 = 4'b0110; data4[32 +: 32] = 32'hB3;
    push4(1, 32'hB3, 1'b1); tick4(4'b0010, "lock_b3");
    v4 = 4'b0100;
    push4(2, 32'hC2, 1'b1); tick4(4'b0100, "lock_release_c2");
    v4 = '0;
    tick4(4'b0000, "lock_idle");
    drain();
    do_reset();

    // Backpressure holds the output register
    v4 = 4'b0001; l4 = 4'b0001; data4[0 +: 32] = 32'hDEADBEEF;
    push4(0, 32'hDEADBEEF, 1'b1); tick4(4'b0001, "bp_accept");
    ir4 = 1'b0; data4[0 +: 32] = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready",  64'(r4),  64'd0);
      chk("bp_valid",  64'(ov4), 64'd1);
      chk("bp_data",   64'(od4), 64'hDEADBEEF);
      @(posedge clk); #1;
    end
    ir4 = 1'b1;
    push4(0, 32'h12345678, 1'b1); tick4(4'b0001, "bp_next");
    v4 = '0;
    drain();
    do_reset();

    // Asynchronous reset in the middle of a ch3 packet
    v4 = 4'b1000; l4 = 4'b0000; data4[96 +: 32] = 32'hD0;
    push4(3, 32'hD0, 1'b0); tick4(4'b1000, "mid_d0");
    data4[96 +: 32] = 32'hD1;
    push4(3, 32'hD1, 1'b0); tick4(4'b1000, "mid_d1");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ov4), 64'd0);
    chk("arst_data",  64'(od4), 64'd0);
    chk("arst_chan",  64'(oc4), 64'd0);
    chk("arst_last",  64'(ol4), 64'd0);
    chk("arst_ready", 64'(r4),  64'd0);
    v4 = 4'b1001; l4 = 4'b1001;
    data4[0 +: 32] = 32'hE0; data4[96 +: 32] = 32'hE3;
    @(posedge clk); #1;
    chk("arst_ready_held", 64'(r4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(r4), 64'b0001);
    push4(0, 32'hE0, 1'b1);
    @(posedge clk); #1;
    push4(3, 32'hE3, 1'b1); tick4(4'b1000, "post_rst_ch3");
    v4 = '0;
    drain();
    do_reset();

    // Single beat then idle: o_valid for exactly one cycle
    v4 = 4'b0100; l4 = 4'b0100; data4[64 +: 32] = 32'hF2;
    push4(2, 32'hF2, 1'b1); tick4(4'b0100, "drain_ready");
    v4 = '0;
    @(negedge clk); chk("drain_valid1", 64'(ov4), 64'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("drain_valid0", 64'(ov4), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("drain_valid0b", 64'(ov4), 64'd0);
    @(posedge clk); #1;
    drain();
    do_reset();

    // Three channels: wrap from ptr=2 and skip idle channels
    l3 = 3'b111;
    v3 = 3'b010; data3[32 +: 32] = 32'h31;
    push3(1, 32'h31, 1'b1); tick3(3'b010, "wrap_ch1");
    v3 = 3'b101; data3[0 +: 32] = 32'h30; data3[64 +: 32] = 32'h32;
    push3(2, 32'h32, 1'b1); tick3(3'b100, "wrap_ch2_first");
    v3 = 3'b001;
    push3(0, 32'h30, 1'b1); tick3(3'b001, "wrap_ch0_next");
    v3 = '0;
    tick3(3'b000, "wrap_idle");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
